// File: rtl/sha256_ctrl.sv
// SHA-256 block sequencer: accepts 512-bit blocks, walks the compression rounds
// and raises digest_valid once the final block of a message has been folded in.
module sha256_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          blk_valid_i,
  input  logic          blk_last_i,
  output logic          blk_ready_o,
  output logic          msg_load_o,
  output logic          msg_shift_o,
  output logic [CW-1:0] round_o,
  output logic          first_blk_o,
  output logic          soc_o,
  output logic          eoc_o,
  output logic          busy_o,
  output logic          digest_valid_o,
  input  logic          digest_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FOLD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [CW-1:0] RLAST = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] RONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] round_q, round_d;
  logic          first_q, first_d;
  logic          last_q,  last_d;

  // State, round counter and message flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= {CW{1'b0}};
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; only IDLE consumes blk_valid and only DONE consumes digest_ack
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (blk_valid_i) begin
          last_d  = blk_last_i;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        round_d = {CW{1'b0}};
        state_d = S_RUN;
      end
      S_RUN: begin
        if (round_q == RLAST) begin
          round_d = {CW{1'b0}};
          state_d = S_FOLD;
        end else begin
          round_d = round_q + RONE;
        end
      end
      S_FOLD: begin
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          first_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (digest_ack_i) begin
          first_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = {CW{1'b0}};
        first_d = 1'b1;
        last_d  = 1'b0;
      end
    endcase
  end

  // Output decode from state only, so no input reaches an output combinationally
  always_comb begin
    blk_ready_o    = 1'b0;
    msg_load_o     = 1'b0;
    msg_shift_o    = 1'b0;
    soc_o          = 1'b0;
    eoc_o          = 1'b0;
    busy_o         = 1'b0;
    digest_valid_o = 1'b0;
    case (state_q)
      S_IDLE: blk_ready_o = 1'b1;
      S_LOAD: begin
        soc_o      = 1'b1;
        msg_load_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_RUN: begin
        msg_shift_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_FOLD: begin
        eoc_o  = 1'b1;
        busy_o = 1'b1;
      end
      S_DONE:  digest_valid_o = 1'b1;
      default: blk_ready_o = 1'b0;
    endcase
  end

  assign round_o     = round_q;
  assign first_blk_o = first_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Scoreboard bench for sha256_ctrl: each accepted block pushes its expected
// soc/eoc cycles and first flag; the strobe monitor pops and compares them.
module tb_sha256_ctrl;

  localparam int R = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blk_valid, blk_last, digest_ack;
  logic       blk_ready, msg_load, msg_shift, first_blk, soc, eoc, busy, digest_valid;
  logic [5:0] round;

  logic       v4, l4, ack4;
  logic       rdy4, load4, shift4, first4, soc4, eoc4, busy4, dv4;
  logic [2:0] round4;

  always #5 clk = ~clk;

  sha256_ctrl #(.ROUNDS(R), .CW(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .blk_valid_i(blk_valid), .blk_last_i(blk_last),
    .blk_ready_o(blk_ready), .msg_load_o(msg_load), .msg_shift_o(msg_shift),
    .round_o(round), .first_blk_o(first_blk), .soc_o(soc), .eoc_o(eoc),
    .busy_o(busy), .digest_valid_o(digest_valid), .digest_ack_i(digest_ack)
  );

  sha256_ctrl #(.ROUNDS(4), .CW(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .blk_valid_i(v4), .blk_last_i(l4),
    .blk_ready_o(rdy4), .msg_load_o(load4), .msg_shift_o(shift4),
    .round_o(round4), .first_blk_o(first4), .soc_o(soc4), .eoc_o(eoc4),
    .busy_o(busy4), .digest_valid_o(dv4), .digest_ack_i(ack4)
  );

  typedef struct {
    logic first;
    logic last;
    int   soc_cyc;
    int   eoc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0, passed = 0;
  int   load_cnt = 0, soc_cnt = 0, eoc_cnt = 0;
  int   dv_due = -1;
  logic dv_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // Per-cycle protocol checks plus scoreboard pop on strobes
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", ((32'(soc) + 32'(eoc) + 32'(msg_shift)) <= 32'd1) ? 32'd1 : 32'd0, 32'd1);
      check("ready_vs_busy", 32'(blk_ready & busy), 32'd0);
      check("dv_vs_busy", 32'(digest_valid & busy), 32'd0);
      if (!msg_shift) check("round_rest", 32'(round), 32'd0);
      if (msg_load) load_cnt++;
      if (soc) soc_cnt++;
      if (eoc) eoc_cnt++;
      if (soc || eoc || msg_shift || msg_load) begin
        if (sb.size() == 0) begin
          check("strobe_without_block", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          check("first_blk", 32'(first_blk), 32'(e.first));
          if (soc) begin
            check("soc_cycle", 32'(cyc), 32'(e.soc_cyc));
            check("soc_with_load", 32'(msg_load), 32'd1);
          end
          if (msg_shift) check("round_seq", 32'(round), 32'(cyc - e.soc_cyc - 1));
          if (eoc) begin
            check("eoc_cycle", 32'(cyc), 32'(e.eoc_cyc));
            dv_due  = cyc + 1;
            dv_last = e.last;
            void'(sb.pop_front());
          end
        end
      end
      if (cyc == dv_due) begin
        check("dv_after_eoc", 32'(digest_valid), 32'(dv_last));
        check("ready_after_eoc", 32'(blk_ready), 32'(!dv_last));
      end
    end
  end

  // Offer a block (called at a negedge); returns at the negedge of its soc
  task automatic send_block(input logic last, input logic exp_first, input logic hold);
    bit found = 1'b0;
    blk_last  = last;
    blk_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (blk_ready) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      check("handshake_timeout", 32'd0, 32'd1);
      blk_valid = 1'b0;
    end else begin
      sb.push_back('{first: exp_first, last: last, soc_cyc: cyc + 1, eoc_cyc: cyc + 1 + R + 1});
      @(posedge clk);
      #1;
      if (!hold) blk_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic finish_digest();
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (digest_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("digest_valid_seen", 32'(found), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("dv_hold", 32'(digest_valid), 32'd1);
      check("done_not_ready", 32'(blk_ready), 32'd0);
    end
    digest_ack = 1'b1;
    @(posedge clk);
    #1 digest_ack = 1'b0;
    @(negedge clk);
    check("ack_ready", 32'(blk_ready), 32'd1);
    check("ack_dv_low", 32'(digest_valid), 32'd0);
    check("ack_first_set", 32'(first_blk), 32'd1);
  endtask

  task automatic wait_ready();
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("ready_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_round(input int r);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (msg_shift && (32'(round) == 32'(r))) begin
        found = 1'b1;
        break;
      end
    end
    check("round_reached", 32'(found), 32'd1);
  endtask

  initial begin
    int lb, sc0, ec0, s4, sh4;
    bit seen;
    rst_n = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; digest_ack = 1'b0;
    v4 = 1'b0; l4 = 1'b0; ack4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      check("idle_ready", 32'(blk_ready), 32'd1);
      check("idle_first", 32'(first_blk), 32'd1);
      check("idle_strobes", 32'({soc, eoc, msg_load, msg_shift, busy, digest_valid}), 32'd0);
    end

    // Single-block message
    send_block(1'b1, 1'b1, 1'b0);
    finish_digest();

    // Three-block message with a stray ack between blocks
    sc0 = soc_cnt; ec0 = eoc_cnt;
    send_block(1'b0, 1'b1, 1'b0);
    wait_ready();
    digest_ack = 1'b1;
    @(posedge clk);
    #1 digest_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored_first", 32'(first_blk), 32'd0);
    check("idle_ack_ignored_ready", 32'(blk_ready), 32'd1);
    send_block(1'b0, 1'b0, 1'b0);
    send_block(1'b1, 1'b0, 1'b0);
    finish_digest();
    check("three_soc", 32'(soc_cnt - sc0), 32'd3);
    check("three_eoc", 32'(eoc_cnt - ec0), 32'd3);

    // blk_valid held through RUN is not consumed
    lb = load_cnt;
    send_block(1'b0, 1'b1, 1'b1);
    wait_round(40);
    check("run_not_ready", 32'(blk_ready), 32'd0);
    check("run_single_load", 32'(load_cnt - lb), 32'd1);
    send_block(1'b1, 1'b0, 1'b0);
    finish_digest();
    check("held_two_loads", 32'(load_cnt - lb), 32'd2);

    // Reset in the middle of RUN
    send_block(1'b1, 1'b1, 1'b0);
    wait_round(30);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(blk_ready), 32'd1);
    check("rst_first", 32'(first_blk), 32'd1);
    check("rst_round", 32'(round), 32'd0);
    check("rst_strobes", 32'({soc, eoc, msg_load, msg_shift, busy, digest_valid}), 32'd0);
    sb.delete();
    ec0 = eoc_cnt;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check("rst_no_eoc", 32'(eoc_cnt - ec0), 32'd0);
    send_block(1'b1, 1'b1, 1'b0);
    finish_digest();

    // ROUNDS=4 instance: soc to eoc is 5 cycles
    v4 = 1'b1; l4 = 1'b1;
    seen = 1'b0; s4 = 0; sh4 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (soc4) begin
        seen = 1'b1;
        break;
      end
    end
    check("r4_soc_seen", 32'(seen), 32'd1);
    s4 = cyc;
    check("r4_soc_load", 32'({load4, busy4, first4, rdy4}), 32'b1110);
    v4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eoc4) begin
        seen = 1'b1;
        break;
      end
      if (shift4) begin
        check("r4_round", 32'(round4), 32'(sh4));
        sh4++;
      end
    end
    check("r4_eoc_seen", 32'(seen), 32'd1);
    check("r4_soc_eoc_gap", 32'(cyc - s4), 32'd5);
    check("r4_shift_count", 32'(sh4), 32'd4);
    @(negedge clk);
    check("r4_dv", 32'(dv4), 32'd1);
    ack4 = 1'b1;
    @(posedge clk);
    #1 ack4 = 1'b0;
    @(negedge clk);
    check("r4_ready_after_ack", 32'({rdy4, dv4}), 32'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
